rtc_time_counter: RTL and testbench

//   Consumes the divided 1 Hz clock level (o_clk of the RTC clock divider) as a

---
 rtl/rtc_pkg.sv | 13 +
 rtl/rtc_bcd_counter.sv | 22 ++
 rtl/rtc_time_counter.sv | 117 +++++++++++
 tb/tb_rtc_time_counter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg: BCD limits, set-handshake FSM states and BCD helpers shared by the RTC time counter
package rtc_pkg;
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] HR24_MAX = 8'h23;
    localparam logic [7:0] HR12_MAX = 8'h12;
    typedef enum logic [1:0] {RUN, CHECK, LOAD, ERR} state_t;
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : {v[7:4], v[3:0] + 4'h1};
    endfunction
    function automatic logic bcd_in(input logic [7:0] v, input logic [7:0] lo, input logic [7:0] hi);
        return (v[7:4] <= 4'h9) && (v[3:0] <= 4'h9) && (v >= lo) && (v <= hi);
    endfunction
endpackage

// File: rtl/rtc_bcd_counter.sv
// rtc_bcd_counter: one BCD time field that wraps MAX_BCD -> MIN_BCD, with a parallel load
module rtc_bcd_counter
    import rtc_pkg::*;
#(
    parameter logic [7:0] MAX_BCD = SEC_MAX,
    parameter logic [7:0] MIN_BCD = 8'h00,
    parameter logic [7:0] RST_BCD = MIN_BCD
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] bcd,
    output logic       carry
);
    assign carry = inc & (bcd == MAX_BCD);
    always_ff @(posedge i_clk or posedge rst)
        if (rst) bcd <= RST_BCD;
        else if (load) bcd <= load_val;
        else if (inc) bcd <= carry ? MIN_BCD : bcd_inc(bcd);
endmodule

// File: rtl/rtc_time_counter.sv
// rtc_time_counter: BCD hh:mm:ss clock stepped by the 1 Hz divider level, with validated set; RTC_ALARM_EN adds an hh:mm alarm
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter bit FMT_24H   = 1'b1,
    parameter bit TICK_EDGE = 1'b1
) (
    input  logic       i_clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_set_valid,
    input  logic [7:0] i_set_hh,
    input  logic [7:0] i_set_mm,
    input  logic [7:0] i_set_ss,
    input  logic       i_set_pm,
    output logic       o_set_ready,
    output logic       o_set_err,
    output logic [7:0] o_hh,
    output logic [7:0] o_mm,
    output logic [7:0] o_ss,
    output logic       o_pm,
    output logic       o_sec_pulse,
    output logic       o_min_pulse
`ifdef RTC_ALARM_EN
    ,
    input  logic [7:0] i_alm_hh,
    input  logic [7:0] i_alm_mm,
    input  logic       i_alm_arm,
    input  logic       i_alm_clr,
    output logic       o_alarm
`endif
);
    localparam logic [7:0] HR_MIN = FMT_24H ? 8'h00 : 8'h01;
    localparam logic [7:0] HR_MAX = FMT_24H ? HR24_MAX : HR12_MAX;
    localparam logic [7:0] HR_RST = FMT_24H ? 8'h00 : HR12_MAX;

    state_t     state, state_nxt;
    logic       tick_d, tick_ev, sec_inc, load, set_ok;
    logic       ss_carry, mm_carry, unused_day_wrap;
    logic [7:0] set_hh, set_mm, set_ss;
    logic       set_pm;

    assign tick_ev = TICK_EDGE ? (i_tick & ~tick_d) : (~i_tick & tick_d);
    // an accepted set request swallows a tick arriving in the same cycle
    assign sec_inc = tick_ev & o_set_ready & ~i_set_valid;
    assign set_ok  = bcd_in(set_ss, 8'h00, SEC_MAX) && bcd_in(set_mm, 8'h00, SEC_MAX)
                  && bcd_in(set_hh, HR_MIN, HR_MAX);

    always_comb begin
        state_nxt   = state;
        o_set_ready = 1'b0;
        o_set_err   = 1'b0;
        load        = 1'b0;
        case (state)
            RUN: begin
                o_set_ready = 1'b1;
                state_nxt   = i_set_valid ? CHECK : RUN;
            end
            CHECK: state_nxt = set_ok ? LOAD : ERR;
            LOAD: begin
                load      = 1'b1;
                state_nxt = RUN;
            end
            default: begin
                o_set_err = 1'b1;
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge rst)
        if (rst) state <= RUN;
        else state <= state_nxt;

    always_ff @(posedge i_clk or posedge rst)
        if (rst) begin
            tick_d      <= 1'b0;
            o_sec_pulse <= 1'b0;
            o_min_pulse <= 1'b0;
            o_pm        <= 1'b0;
            set_hh      <= 8'h00;
            set_mm      <= 8'h00;
            set_ss      <= 8'h00;
            set_pm      <= 1'b0;
        end else begin
            tick_d      <= i_tick;
            o_sec_pulse <= sec_inc;
            o_min_pulse <= ss_carry;
            o_pm        <= !FMT_24H && (load ? set_pm : o_pm ^ (mm_carry && o_hh == 8'h11));
            if (i_set_valid && o_set_ready) begin
                set_hh <= i_set_hh;
                set_mm <= i_set_mm;
                set_ss <= i_set_ss;
                set_pm <= i_set_pm;
            end
        end

    rtc_bcd_counter #(.MAX_BCD(SEC_MAX)) u_ss (
        .i_clk, .rst, .inc(sec_inc), .load, .load_val(set_ss), .bcd(o_ss), .carry(ss_carry)
    );
    rtc_bcd_counter #(.MAX_BCD(SEC_MAX)) u_mm (
        .i_clk, .rst, .inc(ss_carry), .load, .load_val(set_mm), .bcd(o_mm), .carry(mm_carry)
    );
    rtc_bcd_counter #(.MAX_BCD(HR_MAX), .MIN_BCD(HR_MIN), .RST_BCD(HR_RST)) u_hh (
        .i_clk, .rst, .inc(mm_carry), .load, .load_val(set_hh), .bcd(o_hh), .carry(unused_day_wrap)
    );

`ifdef RTC_ALARM_EN
    logic [7:0] alm_mm_nxt, alm_hh_nxt;
    assign alm_mm_nxt = mm_carry ? 8'h00 : bcd_inc(o_mm);
    assign alm_hh_nxt = !mm_carry ? o_hh : (o_hh == HR_MAX) ? HR_MIN : bcd_inc(o_hh);
    always_ff @(posedge i_clk or posedge rst)
        if (rst) o_alarm <= 1'b0;
        else o_alarm <= ~i_alm_clr & (o_alarm | (ss_carry & i_alm_arm
                         & (alm_hh_nxt == i_alm_hh) & (alm_mm_nxt == i_alm_mm)));
`endif
endmodule

// File: tb/tb_rtc_time_counter.sv
// tb_rtc_time_counter: randomized scoreboard bench for a 24 h rising-edge and a 12 h falling-edge rtc_time_counter
module tb_rtc_time_counter;
    typedef struct packed {
        logic        is_set;
        logic        err;
        logic        min;
        logic [24:0] tm;
    } exp_t;

    logic       i_clk = 1'b0, rst = 1'b1, tick = 1'b0, set_valid = 1'b0, set_pm = 1'b0;
    logic [7:0] set_hh = 8'h00, set_mm = 8'h00, set_ss = 8'h00;
    logic [7:0] hh [2], mm [2], ss [2];
    logic       pm [2], rdy [2], err [2], sec [2], mn [2];
`ifdef RTC_ALARM_EN
    logic [7:0] alm_hh = 8'h07, alm_mm = 8'h30;
    logic       alm_arm = 1'b0, alm_clr = 1'b0;
    logic       alarm [2];
`endif
    exp_t        q [2][$];
    int          t [2];
    int          errs [2];
    logic [24:0] cur [2];
    logic        prev_rdy [2];
    int          checks = 0, errors = 0;

    always #10 i_clk = ~i_clk;

    rtc_time_counter #(.FMT_24H(1'b1), .TICK_EDGE(1'b1)) dut24 (
        .i_clk(i_clk), .rst(rst), .i_tick(tick), .i_set_valid(set_valid),
        .i_set_hh(set_hh), .i_set_mm(set_mm), .i_set_ss(set_ss), .i_set_pm(set_pm),
        .o_set_ready(rdy[0]), .o_set_err(err[0]), .o_hh(hh[0]), .o_mm(mm[0]), .o_ss(ss[0]),
        .o_pm(pm[0]), .o_sec_pulse(sec[0]), .o_min_pulse(mn[0])
`ifdef RTC_ALARM_EN
        , .i_alm_hh(alm_hh), .i_alm_mm(alm_mm), .i_alm_arm(alm_arm), .i_alm_clr(alm_clr), .o_alarm(alarm[0])
`endif
    );
    // the 12 h instance sees the inverted level, so its falling-edge event lines up with the rising one
    rtc_time_counter #(.FMT_24H(1'b0), .TICK_EDGE(1'b0)) dut12 (
        .i_clk(i_clk), .rst(rst), .i_tick(~tick), .i_set_valid(set_valid),
        .i_set_hh(set_hh), .i_set_mm(set_mm), .i_set_ss(set_ss), .i_set_pm(set_pm),
        .o_set_ready(rdy[1]), .o_set_err(err[1]), .o_hh(hh[1]), .o_mm(mm[1]), .o_ss(ss[1]),
        .o_pm(pm[1]), .o_sec_pulse(sec[1]), .o_min_pulse(mn[1])
`ifdef RTC_ALARM_EN
        , .i_alm_hh(alm_hh), .i_alm_mm(alm_mm), .i_alm_arm(alm_arm), .i_alm_clr(alm_clr), .o_alarm(alarm[1])
`endif
    );

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual %h required %h", name, d, act, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int n);
        return 8'((n / 10) * 16 + n % 10);
    endfunction

    // seconds-of-day -> {pm, hh, mm, ss} as the given instance should display it
    function automatic logic [24:0] show(input int d, input int s);
        int h   = s / 3600;
        int h12 = (h % 12 == 0) ? 12 : h % 12;
        return {d == 1 && h >= 12, bcd(d == 0 ? h : h12), bcd(s / 60 % 60), bcd(s % 60)};
    endfunction

    function automatic int dec(input logic [7:0] b);
        return (b[7:4] > 4'd9 || b[3:0] > 4'd9) ? -1 : int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    // seconds-of-day a set request loads, or -1 when it must be rejected
    function automatic int set_time(input int d, input logic [7:0] h8, input logic [7:0] m8,
                                    input logic [7:0] s8, input logic p);
        int h = dec(h8), m = dec(m8), s = dec(s8);
        if (h < 0 || m < 0 || s < 0 || m > 59 || s > 59) return -1;
        if (d == 0) return h > 23 ? -1 : h * 3600 + m * 60 + s;
        if (h < 1 || h > 12) return -1;
        return ((h % 12) + (p ? 12 : 0)) * 3600 + m * 60 + s;
    endfunction

    function automatic logic [7:0] rnd_bcd(input int lo, input int hi);
        return ($urandom_range(0, 7) == 0) ? 8'($urandom) : bcd(int'($urandom_range(lo, hi)));
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(rdy[0] && rdy[1]) && n < 20) begin
            cyc(1);
            n++;
        end
        if (n == 20) begin
            errors++;
            $display("FAIL ready_timeout dut0 %b dut1 %b", rdy[0], rdy[1]);
        end
    endtask

    task automatic do_tick(input int hi, input int lo);
        tick = 1'b1;
        for (int d = 0; d < 2; d++) begin
            t[d] = (t[d] + 1) % 86400;
            q[d].push_back('{1'b0, 1'b0, t[d] % 60 == 0, show(d, t[d])});
        end
        cyc(hi);
        tick = 1'b0;
        cyc(lo);
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic p, input logic with_tick);
        int nt;
        wait_ready();
        set_hh = h; set_mm = m; set_ss = s; set_pm = p;
        set_valid = 1'b1;
        tick = with_tick;
        for (int d = 0; d < 2; d++) begin
            nt = set_time(d, h, m, s, p);
            if (nt >= 0) t[d] = nt;
            q[d].push_back('{1'b1, nt < 0, 1'b0, show(d, t[d])});
        end
        cyc(1);
        set_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge i_clk);
            for (int d = 0; d < 2; d++) check("ready_gap", d, rdy[d], k == 3);
        end
        cyc(1);
        tick = 1'b0;
        cyc(1);
    endtask

    always @(negedge i_clk) begin
        exp_t e;
        logic ev;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                q[d].delete();
                errs[d]     = 0;
                prev_rdy[d] = 1'b1;
                cur[d]      = show(d, 0);
            end else begin
                ev = sec[d] | (rdy[d] & ~prev_rdy[d]);
                if (err[d]) errs[d]++;
                if (ev) begin
                    if (q[d].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event dut%0d sec %b time %h", d, sec[d],
                                 {pm[d], hh[d], mm[d], ss[d]});
                    end else begin
                        e = q[d].pop_front();
                        check("event_kind", d, sec[d], !e.is_set);
                        check("min_pulse", d, mn[d], e.min);
                        if (e.is_set) check("set_err", d, errs[d], e.err);
                        errs[d] = 0;
                        cur[d]  = e.tm;
                    end
                end else check("min_idle", d, mn[d], 1'b0);
                check("time", d, {pm[d], hh[d], mm[d], ss[d]}, cur[d]);
                prev_rdy[d] = rdy[d];
            end
        end
    end

    initial begin
        t[0] = 0;
        t[1] = 0;
        cyc(3);
        for (int d = 0; d < 2; d++) begin
            check("rst_time", d, {pm[d], hh[d], mm[d], ss[d]}, show(d, 0));
            check("rst_ready", d, rdy[d], 1'b1);
            check("rst_strobes", d, {err[d], sec[d], mn[d]}, 3'b000);
        end
        rst = 1'b0;
        cyc(2);
        repeat (3) do_tick(2, 2);
        do_set(8'h23, 8'h59, 8'h58, 1'b0, 1'b0);
        do_tick(1, 1);
        do_tick(1, 3);
        do_set(8'h11, 8'h59, 8'h59, 1'b0, 1'b0);
        do_tick(3, 1);
        do_set(8'h24, 8'h00, 8'h00, 1'b0, 1'b0);
        do_set(8'h12, 8'h6A, 8'h00, 1'b1, 1'b0);
        do_set(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_tick(1, 1);
        do_set(8'h10, 8'h00, 8'h00, 1'b0, 1'b1);
        do_tick(1, 2);
        // reset while a set request sits in the validation step
        wait_ready();
        set_hh = 8'h05; set_mm = 8'h00; set_ss = 8'h00; set_valid = 1'b1;
        cyc(1);
        set_valid = 1'b0;
        rst = 1'b1;
        t[0] = 0;
        t[1] = 0;
        cyc(1);
        for (int d = 0; d < 2; d++) begin
            check("midset_time", d, {pm[d], hh[d], mm[d], ss[d]}, show(d, 0));
            check("midset_ready", d, rdy[d], 1'b1);
            check("midset_err", d, err[d], 1'b0);
        end
        // a level already high when reset lifts counts once on the rising-edge instance
        tick = 1'b1;
        cyc(2);
        rst = 1'b0;
        t[0] = 1;
        q[0].push_back('{1'b0, 1'b0, 1'b0, show(0, 1)});
        cyc(3);
        tick = 1'b0;
        cyc(3);
        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(0, 9));
            if (r < 7) do_tick(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            else do_set(rnd_bcd(0, 23), rnd_bcd(50, 59), rnd_bcd(55, 59),
                        1'($urandom_range(0, 1)), r == 9);
        end
        for (int n = 0; n < 50 && (q[0].size() != 0 || q[1].size() != 0); n++) cyc(1);
        for (int d = 0; d < 2; d++) check("drain", d, q[d].size(), 0);
`ifdef RTC_ALARM_EN
        for (int d = 0; d < 2; d++) check("alarm_idle", d, alarm[d], 1'b0);
        alm_arm = 1'b1;
        do_set(8'h07, 8'h30, 8'h00, 1'b0, 1'b0);
        cyc(2);
        for (int d = 0; d < 2; d++) check("alarm_on_load", d, alarm[d], 1'b0);
        do_set(8'h07, 8'h29, 8'h59, 1'b0, 1'b0);
        do_tick(1, 1);
        cyc(3);
        for (int d = 0; d < 2; d++) check("alarm_hold", d, alarm[d], 1'b1);
        alm_clr = 1'b1;
        cyc(1);
        alm_clr = 1'b0;
        for (int d = 0; d < 2; d++) check("alarm_clr", d, alarm[d], 1'b0);
        alm_arm = 1'b0;
        cyc(3);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
